// File: rtl/i2c_mem_target.sv
// rtl/i2c_mem_target.sv - I2C target serving a 256-byte internal memory with auto-incrementing pointer
//
// Optional build macro: I2C_TGT_WP_EN (adds write-protect input wp)
//
// Ports:
//   clk        system clock, oversamples scl/sda_in (must be >= 8x SCL)
//   rst        asynchronous active-low reset
//   scl        I2C clock from master
//   sda_in     sampled SDA line
//   sda_oe     1 = pull SDA low, 0 = release
//   pre_we     preload write strobe (ignored while busy)
//   pre_addr   preload address
//   pre_wdata  preload data
//   wp         (I2C_TGT_WP_EN only) 1 = NACK and drop data bytes
//   busy       high from matched address until STOP or NACK-terminated read
//   ptr        current word pointer
`timescale 1ns/1ps

module i2c_mem_target #(
  parameter logic [6:0] DEV_ADDR  = 7'h50,
  parameter int         MEM_DEPTH = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic       pre_we,
  input  logic [7:0] pre_addr,
  input  logic [7:0] pre_wdata,
`ifdef I2C_TGT_WP_EN
  input  logic       wp,
`endif
  output logic       busy,
  output logic [7:0] ptr
);

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_PTR,
    WR_ACK,
    WR_DATA,
    RD_BYTE,
    RD_ACK,
    WAIT_STOP
  } state_t;

  state_t     state;
  logic [3:0] bit_cnt;
  logic [7:0] shreg;
  logic [7:0] tx;
  logic       rw;

  logic [7:0] mem [MEM_DEPTH];

  // Synchronizers plus one delayed copy for edge detection. Reset to the
  // idle-bus level so releasing reset never looks like a START.
  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_s1 <= scl;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= sda_in;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;

  logic wr_blocked;
`ifdef I2C_TGT_WP_EN
  assign wr_blocked = wp;
`else
  assign wr_blocked = 1'b0;
`endif

  logic [7:0] rd_byte;
  assign rd_byte = mem[ptr];

  // Bus write fires on the 8th falling edge of a data byte; START/STOP
  // cannot coincide with a falling SCL edge but are masked for clarity.
  logic bus_we;
  assign bus_we = (state == WR_DATA) && scl_fall && (bit_cnt == 4'd8) &&
                  !wr_blocked && !start_det && !stop_det;

  // Memory has no reset so contents survive a mid-transfer reset.
  always_ff @(posedge clk) begin
    if (bus_we)
      mem[ptr] <= shreg;
    else if (pre_we && !busy)
      mem[pre_addr] <= pre_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      ptr     <= 8'h00;
      bit_cnt <= 4'd0;
      shreg   <= 8'h00;
      tx      <= 8'h00;
      rw      <= 1'b0;
    end else if (stop_det) begin
      state  <= IDLE;
      sda_oe <= 1'b0;
      busy   <= 1'b0;
    end else if (start_det) begin
      state   <= ADDR;
      bit_cnt <= 4'd0;
      sda_oe  <= 1'b0;
    end else begin
      case (state)
        ADDR, WR_PTR, WR_DATA: begin
          if (scl_rise) begin
            shreg   <= {shreg[6:0], sda_s2};
            bit_cnt <= bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            bit_cnt <= 4'd0;
            if (state == ADDR) begin
              if (shreg[7:1] == DEV_ADDR) begin
                state  <= ADDR_ACK;
                sda_oe <= 1'b1;
                busy   <= 1'b1;
                rw     <= shreg[0];
              end else begin
                state  <= WAIT_STOP;
                sda_oe <= 1'b0;
              end
            end else if (state == WR_PTR) begin
              ptr    <= shreg;
              sda_oe <= 1'b1;
              state  <= WR_ACK;
            end else begin
              // Protected bytes leave SDA released in the ACK slot (NACK).
              state <= WR_ACK;
              if (!wr_blocked) begin
                ptr    <= ptr + 8'd1;
                sda_oe <= 1'b1;
              end else begin
                sda_oe <= 1'b0;
              end
            end
          end
        end

        ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt <= 4'd0;
            if (rw) begin
              state  <= RD_BYTE;
              tx     <= rd_byte;
              sda_oe <= ~rd_byte[7];
            end else begin
              state  <= WR_PTR;
              sda_oe <= 1'b0;
            end
          end
        end

        WR_ACK: begin
          if (scl_fall) begin
            bit_cnt <= 4'd0;
            sda_oe  <= 1'b0;
            state   <= WR_DATA;
          end
        end

        RD_BYTE: begin
          if (scl_rise) begin
            bit_cnt <= bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe  <= 1'b0;
              state   <= RD_ACK;
              ptr     <= ptr + 8'd1;
              bit_cnt <= 4'd0;
            end else begin
              // tx[7] is already on the bus; shift so tx[7] tracks the driven bit.
              tx     <= {tx[6:0], 1'b0};
              sda_oe <= ~tx[6];
            end
          end
        end

        RD_ACK: begin
          // bit_cnt==1 marks an ACK seen on the 9th rising edge.
          if (scl_rise) begin
            if (sda_s2) begin
              state <= WAIT_STOP;
              busy  <= 1'b0;
            end else begin
              bit_cnt <= 4'd1;
            end
          end else if (scl_fall && bit_cnt == 4'd1) begin
            bit_cnt <= 4'd0;
            state   <= RD_BYTE;
            tx      <= rd_byte;
            sda_oe  <= ~rd_byte[7];
          end
        end

        WAIT_STOP: sda_oe <= 1'b0;

        default: begin
          state  <= IDLE;
          sda_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_mem_target.sv
// tb/tb_i2c_mem_target.sv - directed bus-level bench for i2c_mem_target
`timescale 1ns/1ps

module tb_i2c_mem_target;

  localparam int Q = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_line;
  logic       sda_oe;
  logic       pre_we = 1'b0;
  logic [7:0] pre_addr = 8'h00;
  logic [7:0] pre_wdata = 8'h00;
  logic       busy;
  logic [7:0] ptr;
`ifdef I2C_TGT_WP_EN
  logic       wp = 1'b0;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int oe_cnt   = 0;

  assign sda_line = m_sda & ~sda_oe;

  i2c_mem_target dut (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda_in    (sda_line),
    .sda_oe    (sda_oe),
    .pre_we    (pre_we),
    .pre_addr  (pre_addr),
    .pre_wdata (pre_wdata),
`ifdef I2C_TGT_WP_EN
    .wp        (wp),
`endif
    .busy      (busy),
    .ptr       (ptr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (sda_oe) oe_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pre_addr  = a;
    pre_wdata = d;
    pre_we    = 1'b1;
    #10;
    pre_we    = 1'b0;
  endtask

  task automatic bus_start;
    m_sda = 1'b1; #Q;
    scl   = 1'b1; #Q;
    m_sda = 1'b0; #Q;
    scl   = 1'b0; #Q;
  endtask

  task automatic bus_stop;
    m_sda = 1'b0; #Q;
    scl   = 1'b1; #Q;
    m_sda = 1'b1; #Q;
  endtask

  task automatic send_bit(input logic b);
    m_sda = b; #Q;
    scl   = 1'b1; #(2*Q);
    scl   = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    m_sda = 1'b1; #Q;
    scl   = 1'b1; #Q;
    ack   = sda_line; #Q;
    scl   = 1'b0; #Q;
  endtask

  task automatic read_byte(input logic give_ack, output logic [7:0] b);
    b     = 8'h00;
    m_sda = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #Q; scl = 1'b1;
      #Q; b = {b[6:0], sda_line};
      #Q; scl = 1'b0;
      #Q;
    end
    m_sda = ~give_ack; #Q;
    scl   = 1'b1; #(2*Q);
    scl   = 1'b0; #Q;
    m_sda = 1'b1;
  endtask

  // START, write address, pointer, repeated START, read address.
  task automatic begin_read(input logic [7:0] p, input string tag);
    logic ack;
    bus_start;
    write_byte(8'hA0, ack); check({tag, "_ack_wa"}, ack, 1'b0);
    write_byte(p, ack);     check({tag, "_ack_ptr"}, ack, 1'b0);
    bus_start;
    write_byte(8'hA1, ack); check({tag, "_ack_ra"}, ack, 1'b0);
  endtask

  initial begin
    #(3ms);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack;
    logic [7:0] b;
    logic [7:0] exp_rd [4];
    int         oe_before;

    exp_rd[0] = 8'hA1; exp_rd[1] = 8'hB2; exp_rd[2] = 8'hC3; exp_rd[3] = 8'hD4;

    #22;
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ptr", ptr, 8'h00);
    rst = 1'b1;
    #Q;

    preload(8'h10, 8'hA1);
    preload(8'h11, 8'hB2);
    preload(8'h12, 8'hC3);
    preload(8'h13, 8'hD4);
    preload(8'h20, 8'h77);
    preload(8'h40, 8'h5A);
    #Q;

    // Sequential read of four preloaded bytes.
    begin_read(8'h10, "t1");
    check("t1_busy_mid", busy, 1'b1);
    for (int i = 0; i < 4; i++) begin
      read_byte(i != 3, b);
      check($sformatf("t1_rd%0d", i), b, exp_rd[i]);
    end
    check("t1_busy_after_nack", busy, 1'b0);
    check("t1_ptr", ptr, 8'h14);
    bus_stop;

    // Write across the pointer wrap, then read back.
    bus_start;
    write_byte(8'hA0, ack); check("t2_ack_wa", ack, 1'b0);
    write_byte(8'hFE, ack); check("t2_ack_ptr", ack, 1'b0);
    write_byte(8'h11, ack); check("t2_ack_d0", ack, 1'b0);
    write_byte(8'h22, ack); check("t2_ack_d1", ack, 1'b0);
    write_byte(8'h33, ack); check("t2_ack_d2", ack, 1'b0);
    bus_stop;
    check("t2_ptr_wrap", ptr, 8'h01);
    check("t2_busy_stop", busy, 1'b0);
    begin_read(8'hFE, "t2r");
    read_byte(1'b1, b); check("t2_rd_fe", b, 8'h11);
    read_byte(1'b1, b); check("t2_rd_ff", b, 8'h22);
    read_byte(1'b0, b); check("t2_rd_00", b, 8'h33);
    check("t2_ptr_after_rd", ptr, 8'h01);
    bus_stop;

    // Wrong address: target stays silent until STOP.
    oe_before = oe_cnt;
    bus_start;
    write_byte(8'hA2, ack); check("t3_nack_addr", ack, 1'b1);
    check("t3_busy", busy, 1'b0);
    write_byte(8'h55, ack); check("t3_nack_data", ack, 1'b1);
    bus_stop;
    check("t3_oe_never", oe_cnt - oe_before, 0);
    check("t3_ptr_kept", ptr, 8'h01);
    begin_read(8'h10, "t3r");
    read_byte(1'b0, b); check("t3_rd_after", b, 8'hA1);
    bus_stop;

    // STOP in the middle of a data byte: no write.
    bus_start;
    write_byte(8'hA0, ack); check("t4_ack_wa", ack, 1'b0);
    write_byte(8'h40, ack); check("t4_ack_ptr", ack, 1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    bus_stop;
    check("t4_busy", busy, 1'b0);
    check("t4_ptr", ptr, 8'h40);
    begin_read(8'h40, "t4r");
    read_byte(1'b0, b); check("t4_mem_kept", b, 8'h5A);
    bus_stop;

    // Reset while the target is driving a 0 data bit (bit 3 of 8'hA1).
    begin_read(8'h10, "t5");
    for (int i = 0; i < 4; i++) begin
      #Q; scl = 1'b1;
      #(2*Q); scl = 1'b0;
      #Q;
    end
    check("t5_driving_low", sda_oe, 1'b1);
    rst = 1'b0;
    #1;
    check("t5_async_oe", sda_oe, 1'b0);
    check("t5_busy", busy, 1'b0);
    check("t5_ptr", ptr, 8'h00);
    #19;
    rst   = 1'b1;
    m_sda = 1'b1; #Q;
    scl   = 1'b1; #Q;
    begin_read(8'h10, "t5r");
    read_byte(1'b1, b); check("t5_mem10", b, 8'hA1);
    read_byte(1'b0, b); check("t5_mem11", b, 8'hB2);
    bus_stop;

`ifdef I2C_TGT_WP_EN
    // Write-protect: pointer ACKed, data NACKed and dropped.
    wp = 1'b1;
    bus_start;
    write_byte(8'hA0, ack); check("t6_ack_wa", ack, 1'b0);
    write_byte(8'h20, ack); check("t6_ack_ptr", ack, 1'b0);
    write_byte(8'h55, ack); check("t6_nack_data", ack, 1'b1);
    bus_stop;
    check("t6_ptr", ptr, 8'h20);
    wp = 1'b0;
    begin_read(8'h20, "t6r");
    read_byte(1'b0, b); check("t6_mem20", b, 8'h77);
    bus_stop;
`endif

    #Q;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/i2c_mem_target.md
Name: i2c_mem_target

Overview:
- I2C target (slave) that answers the I2C master in the controller and serves bytes from an internal byte memory.
- Lets the FSMD run against a simulated or on-chip data source.
- Supports pointer-set writes, sequential data writes, sequential reads, repeated START, and auto-incrementing pointer with wrap.
- A host-side preload port fills the memory before the FSMD starts.

Parameters:
- DEV_ADDR, 7'h50, 7-bit target address matched after START.
- MEM_DEPTH, 256, bytes of internal memory. Must equal 256: an 8-bit pointer addresses all of it.

Ports:
- clk  input  1  system clock; SCL/SDA are oversampled on it
- rst  input  1  asynchronous, active-low reset
- scl  input  1  I2C clock from master
- sda_in  input  1  sampled SDA line
- sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release
- pre_we  input  1  preload write strobe
- pre_addr  input  8  preload address
- pre_wdata  input  8  preload data
- busy  output  1  high from START with address match until STOP or NACK-terminated read
- ptr  output  8  current word pointer

Behaviour:
- Reset (rst=0, asynchronous): sda_oe=0, busy=0, ptr=0, state=IDLE, bit counter=0. Memory contents are not cleared.
- scl and sda_in each pass through a 2-flop synchronizer. Edges are detected on the synchronized values, so there is 2-3 clk latency.
- Requirement: clk must be at least 8x the SCL frequency.
- START = SDA falls while SCL high. STOP = SDA rises while SCL high.
  - START/STOP are detected in any state and take priority over bit processing.
  - STOP -> IDLE, sda_oe=0, busy=0.
  - START (including repeated START) -> ADDR, bit counter=0.
- Data bits are sampled on the SCL rising edge, MSB first. sda_oe changes only on the SCL falling edge, one clk after detection.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. On the 8th falling edge:
    - {addr,rw} match DEV_ADDR -> ADDR_ACK, assert sda_oe, busy=1.
    - Mismatch -> WAIT_STOP with sda_oe=0.
  - ADDR_ACK: on the 9th falling edge, release the ACK.
    - rw=0 -> WR_PTR.
    - rw=1 -> RD_BYTE; drive the MSB of mem[ptr] in the same cycle (sda_oe = ~bit).
  - WR_PTR: shift 8 bits; on the 8th falling edge ptr<=byte and ACK. After the ACK -> WR_DATA.
  - WR_DATA: shift 8 bits; on the 8th falling edge mem[ptr]<=byte, ptr<=ptr+1 (wrap 255->0), then ACK. After the ACK -> WR_DATA.
  - RD_BYTE: on each falling edge drive the next bit of mem[ptr]. After bit 7's falling edge, release SDA -> RD_ACK and ptr<=ptr+1 (wraps).
  - RD_ACK: sample SDA on the 9th rising edge.
    - 0 (ACK) -> RD_BYTE, driving the MSB of the new mem[ptr] at the 9th falling edge.
    - 1 (NACK) -> WAIT_STOP, busy=0.
  - WAIT_STOP: sda_oe=0; leave only on STOP or START.
- Preload: pre_we writes mem[pre_addr]<=pre_wdata on clk.
  - Ignored while busy=1.
  - On a same-cycle collision with a bus write, the bus write wins.
- Reset mid-transfer releases SDA immediately and returns to IDLE. Memory contents and any completed bus writes are kept.

Optional Feature:
- Macro: I2C_TGT_WP_EN.
- When defined:
  - Adds input wp (1 bit).
  - While wp=1, bytes in WR_DATA are NACKed (sda_oe stays 0 in the ACK slot), mem is not written, and ptr does not increment. The state stays WR_DATA.
  - The pointer byte (WR_PTR) is always ACKed.
- When undefined: no wp port; all writes proceed as above.

Test Plan:
- Preload mem[8'h10..8'h13]=8'hA1,B2,C3,D4. Master: START, 8'hA0, 8'h10, repeated START, 8'hA1, read 4 bytes (ACK,ACK,ACK,NACK), STOP -> three ACKs by target; data A1,B2,C3,D4; ptr=8'h14; busy=0 after the NACK.
- START, 8'hA0, ptr 8'hFE, data 8'h11,22,33, STOP; then read 3 from 8'hFE -> mem[FE]=11, [FF]=22, [00]=33; read returns 11,22,33 with wrap.
- START, 8'hA2 (wrong address) -> sda_oe never asserts; busy=0; target ignores bytes until STOP; the next valid transfer works.
- Assert rst=0 mid-read (bit 3, SDA driven low) -> sda_oe=0 asynchronously; state IDLE, ptr=0; preloaded data intact.
- STOP injected mid-byte during WR_DATA -> partial byte discarded, no mem write; IDLE, busy=0.
- With I2C_TGT_WP_EN, wp=1: write 8'h55 to ptr 8'h20 -> pointer ACKed, data NACKed; mem[20] unchanged; ptr=8'h20.
